// File: rtl/inv_filt_bank.sv
// Bank of WIDTH input conditioners: 2-flop synchroniser, consecutive-sample glitch
// filter and per-channel invert select, with a registered change strobe.
module inv_filt_bank #(
    parameter int WIDTH = 8,
    parameter int FILT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] inv_en,
    output logic [WIDTH-1:0] Y,
    output logic             chg
);

    localparam int            CW      = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

    logic [WIDTH-1:0]         s1_q;
    logic [WIDTH-1:0]         s2_q;
    logic [WIDTH-1:0]         st_q;
    logic [WIDTH-1:0]         st_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q;
    logic [WIDTH-1:0][CW-1:0] cnt_d;
    logic [WIDTH-1:0]         y_q;
    logic [WIDTH-1:0]         y_d;
    logic                     chg_pend_q;
    logic                     chg_pend_d;
    logic                     chg_q;

    // Any sample agreeing with the filtered level drops the count back to zero.
    always_comb begin
        st_d  = st_q;
        cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] != st_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    st_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // chg trails the Y update by one edge, so the change is flagged after it lands.
    assign y_d        = st_q ^ inv_en;
    assign chg_pend_d = |(y_d ^ y_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            st_q       <= '0;
            cnt_q      <= '0;
            y_q        <= '1;
            chg_pend_q <= 1'b0;
            chg_q      <= 1'b0;
        end else begin
            s1_q       <= A;
            s2_q       <= s1_q;
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            y_q        <= y_d;
            chg_pend_q <= chg_pend_d;
            chg_q      <= chg_pend_q;
        end
    end

    assign Y   = y_q;
    assign chg = chg_q;

endmodule
